// File: rtl/pc_pkg.sv
// Shared op encodings and stack-control bundle for the pc_rstack program counter.
package pc_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_HOLD = 3'b000;
   localparam logic [OP_W-1:0] OP_INCR = 3'b001;
   localparam logic [OP_W-1:0] OP_LOAD = 3'b010;
   localparam logic [OP_W-1:0] OP_REL  = 3'b011;
   localparam logic [OP_W-1:0] OP_CALL = 3'b100;
   localparam logic [OP_W-1:0] OP_RET  = 3'b101;

   typedef struct packed {
      logic push;
      logic pop;
      logic err;
   } stk_ctrl_t;

endpackage

// File: rtl/pc_lifo.sv
// Return-address LIFO; the pointer counts occupied entries and full/empty are registered.
module pc_lifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_ptr_d;
   logic             r_full;
   logic             r_empty;
   logic             w_do_push;
   logic             w_do_pop;
   logic [IDX_W-1:0] w_top_idx;

   assign w_do_push = i_push && !r_full;
   assign w_do_pop  = i_pop && !r_empty && !i_push;
   assign w_top_idx = r_ptr[IDX_W-1:0] - IDX_W'(1);

   always_comb begin
      w_ptr_d = r_ptr;
      if (w_do_push) begin
         w_ptr_d = r_ptr + PTR_W'(1);
      end else if (w_do_pop) begin
         w_ptr_d = r_ptr - PTR_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ptr   <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_ptr   <= w_ptr_d;
         r_full  <= (w_ptr_d == PTR_W'(DEPTH));
         r_empty <= (w_ptr_d == '0);
      end
   end

   // Contents are left unreset; only the pointer defines validity.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_ptr[IDX_W-1:0]] <= i_din;
      end
   end

   assign o_dout  = r_mem[w_top_idx];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/pc_rstack.sv
// Program counter with relative branch and CALL/RET return stack.
// Optional breakpoint compare enabled by defining PC_RSTACK_BRK_EN.
module pc_rstack
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [OP_W-1:0]  i_op,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_result,
   output logic             o_stk_full,
   output logic             o_stk_empty,
   output logic             o_stk_err
`ifdef PC_RSTACK_BRK_EN
   ,
   input  logic [WIDTH-1:0] i_brk_addr,
   input  logic             i_brk_arm,
   input  logic             i_brk_clr,
   output logic             o_brk_hit
`endif
);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_next;
   logic [WIDTH-1:0] w_pc_inc;
   logic [WIDTH-1:0] w_stk_top;
   logic             w_stk_full;
   logic             w_stk_empty;
   logic             r_err;
   stk_ctrl_t        w_ctrl;

   assign w_pc_inc = r_pc + WIDTH'(1);

`ifdef PC_RSTACK_BRK_EN
   logic r_brk_hit;
   logic w_brk_hit_d;
`endif

   always_comb begin
      w_pc_next = r_pc;
      w_ctrl    = '0;
      case (i_op)
         OP_INCR: w_pc_next = w_pc_inc;
         OP_LOAD: w_pc_next = i_data;
         OP_REL:  w_pc_next = r_pc + i_data;
         OP_CALL: begin
            // Target loads even on overflow; only the push is lost.
            w_pc_next = i_data;
            if (w_stk_full) begin
               w_ctrl.err = 1'b1;
            end else begin
               w_ctrl.push = 1'b1;
            end
         end
         OP_RET: begin
            if (w_stk_empty) begin
               w_ctrl.err = 1'b1;
            end else begin
               w_pc_next  = w_stk_top;
               w_ctrl.pop = 1'b1;
            end
         end
         default: ;
      endcase
`ifdef PC_RSTACK_BRK_EN
      if (r_brk_hit) begin
         w_pc_next = r_pc;
         w_ctrl    = '0;
      end
`endif
   end

`ifdef PC_RSTACK_BRK_EN
   always_comb begin
      w_brk_hit_d = r_brk_hit;
      if (i_brk_clr) begin
         w_brk_hit_d = 1'b0;
      end else if (!r_brk_hit && i_brk_arm && (w_pc_next == i_brk_addr)) begin
         w_brk_hit_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_brk_hit <= 1'b0;
      end else begin
         r_brk_hit <= w_brk_hit_d;
      end
   end

   assign o_brk_hit = r_brk_hit;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pc  <= RESET_VEC;
         r_err <= 1'b0;
      end else begin
         r_pc  <= w_pc_next;
         r_err <= r_err | w_ctrl.err;
      end
   end

   pc_lifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_lifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_ctrl.push),
      .i_pop   (w_ctrl.pop),
      .i_din   (w_pc_inc),
      .o_dout  (w_stk_top),
      .o_full  (w_stk_full),
      .o_empty (w_stk_empty)
   );

   assign o_result    = r_pc;
   assign o_stk_full  = w_stk_full;
   assign o_stk_empty = w_stk_empty;
   assign o_stk_err   = r_err;

endmodule

// File: tb/tb_pc_rstack.sv
// Directed bench for pc_rstack at WIDTH=8, DEPTH=4, RESET_VEC=00.
module tb_pc_rstack;
   import pc_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [2:0] op;
   logic [7:0] data;
   logic [7:0] result;
   logic       stk_full;
   logic       stk_empty;
   logic       stk_err;
`ifdef PC_RSTACK_BRK_EN
   logic [7:0] brk_addr;
   logic       brk_arm;
   logic       brk_clr;
   logic       brk_hit;
`endif

   int checks   = 0;
   int failures = 0;

   pc_rstack #(
      .WIDTH     (8),
      .DEPTH     (4),
      .RESET_VEC (8'h00)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_op        (op),
      .i_data      (data),
      .o_result    (result),
      .o_stk_full  (stk_full),
      .o_stk_empty (stk_empty),
      .o_stk_err   (stk_err)
`ifdef PC_RSTACK_BRK_EN
      ,
      .i_brk_addr  (brk_addr),
      .i_brk_arm   (brk_arm),
      .i_brk_clr   (brk_clr),
      .o_brk_hit   (brk_hit)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one op for one edge, then sample 1 time unit after the edge.
   task automatic step(input logic [2:0] o, input logic [7:0] d);
      op   = o;
      data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_flags(input string tag, input logic f, input logic e, input logic r);
      check({tag, "_full"}, 32'(stk_full), 32'(f));
      check({tag, "_empty"}, 32'(stk_empty), 32'(e));
      check({tag, "_err"}, 32'(stk_err), 32'(r));
   endtask

   initial begin
      rst_n = 1'b0;
      op    = OP_HOLD;
      data  = 8'h00;
`ifdef PC_RSTACK_BRK_EN
      brk_addr = 8'h00;
      brk_arm  = 1'b0;
      brk_clr  = 1'b0;
`endif
      step(OP_INCR, 8'h00);
      step(OP_CALL, 8'h33);
      check("reset_pc", 32'(result), 32'h00);
      check_flags("reset", 1'b0, 1'b1, 1'b0);
      rst_n = 1'b1;

      // 1: increment and wrap
      step(OP_INCR, 8'h00); check("incr1", 32'(result), 32'h01);
      step(OP_INCR, 8'h00); check("incr2", 32'(result), 32'h02);
      step(OP_INCR, 8'h00); check("incr3", 32'(result), 32'h03);
      step(OP_LOAD, 8'hFE); check("load_fe", 32'(result), 32'hFE);
      step(OP_INCR, 8'h00); check("incr_ff", 32'(result), 32'hFF);
      step(OP_INCR, 8'h00); check("incr_wrap", 32'(result), 32'h00);

      // 2: relative branches
      step(OP_LOAD, 8'h42); check("load_42", 32'(result), 32'h42);
      step(OP_REL, 8'hFE);  check("rel_m2", 32'(result), 32'h40);
      step(OP_REL, 8'h05);  check("rel_p5", 32'(result), 32'h45);
      step(OP_LOAD, 8'h02); check("load_02", 32'(result), 32'h02);
      step(OP_REL, 8'hFC);  check("rel_wrap", 32'(result), 32'hFE);
      step(OP_HOLD, 8'h77); check("hold", 32'(result), 32'hFE);
      step(3'b111, 8'h77);  check("rsvd_111", 32'(result), 32'hFE);
      step(3'b110, 8'h77);  check("rsvd_110", 32'(result), 32'hFE);

      // 3: single call / return
      step(OP_LOAD, 8'h10);
      step(OP_CALL, 8'h80); check("call_80", 32'(result), 32'h80);
      check_flags("call1", 1'b0, 1'b0, 1'b0);
      step(OP_RET, 8'h00);  check("ret_11", 32'(result), 32'h11);
      check_flags("ret1", 1'b0, 1'b1, 1'b0);

      // 4: nest to overflow, unwind to underflow
      step(OP_LOAD, 8'h00);
      step(OP_CALL, 8'h20); check("call_20", 32'(result), 32'h20);
      step(OP_CALL, 8'h30); check("call_30", 32'(result), 32'h30);
      step(OP_CALL, 8'h40);
      check_flags("call3", 1'b0, 1'b0, 1'b0);
      step(OP_CALL, 8'h50); check("call_50", 32'(result), 32'h50);
      check_flags("call4", 1'b1, 1'b0, 1'b0);
      step(OP_CALL, 8'h60); check("call_ovf", 32'(result), 32'h60);
      check_flags("ovf", 1'b1, 1'b0, 1'b1);
      step(OP_RET, 8'h00);  check("ret_41", 32'(result), 32'h41);
      check("ret_41_full", 32'(stk_full), 32'h0);
      step(OP_RET, 8'h00);  check("ret_31", 32'(result), 32'h31);
      step(OP_RET, 8'h00);  check("ret_21", 32'(result), 32'h21);
      step(OP_RET, 8'h00);  check("ret_01", 32'(result), 32'h01);
      check_flags("ret4", 1'b0, 1'b1, 1'b1);
      step(OP_RET, 8'h00);  check("ret_unf", 32'(result), 32'h01);
      check_flags("unf", 1'b0, 1'b1, 1'b1);

      // 5: reset overrides an in-flight CALL
      step(OP_CALL, 8'hA0);
      step(OP_CALL, 8'hB0); check("pre_rst", 32'(result), 32'hB0);
      rst_n = 1'b0;
      step(OP_CALL, 8'h90); check("mid_rst_pc", 32'(result), 32'h00);
      check_flags("mid_rst", 1'b0, 1'b1, 1'b0);
      rst_n = 1'b1;
      step(OP_INCR, 8'h00); check("post_rst", 32'(result), 32'h01);

`ifdef PC_RSTACK_BRK_EN
      // 6: breakpoint
      step(OP_LOAD, 8'h00);
      brk_arm  = 1'b1;
      brk_addr = 8'h05;
      for (int i = 1; i <= 4; i++) begin
         step(OP_INCR, 8'h00);
      end
      check("brk_pre_pc", 32'(result), 32'h04);
      check("brk_pre_hit", 32'(brk_hit), 32'h0);
      step(OP_INCR, 8'h00); check("brk_hit_pc", 32'(result), 32'h05);
      check("brk_hit", 32'(brk_hit), 32'h1);
      for (int i = 0; i < 3; i++) begin
         step(OP_INCR, 8'h00);
      end
      check("brk_frozen_pc", 32'(result), 32'h05);
      step(OP_CALL, 8'hC0); check("brk_frozen_call", 32'(result), 32'h05);
      check_flags("brk_frozen", 1'b0, 1'b1, 1'b0);
      brk_clr = 1'b1;
      step(OP_INCR, 8'h00); check("brk_clr_pc", 32'(result), 32'h05);
      check("brk_clr_hit", 32'(brk_hit), 32'h0);
      brk_clr = 1'b0;
      step(OP_INCR, 8'h00); check("brk_resume", 32'(result), 32'h06);
      check("brk_resume_hit", 32'(brk_hit), 32'h0);
      // Clear wins over a same-cycle match; PC still moves.
      step(OP_LOAD, 8'h04);
      brk_clr = 1'b1;
      step(OP_INCR, 8'h00); check("clr_win_pc", 32'(result), 32'h05);
      check("clr_win_hit", 32'(brk_hit), 32'h0);
      brk_clr = 1'b0;
      brk_arm = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
